// File: rtl/fetch_redirect_pkg.sv
// Shared fetch-stage types: reset PC, FSM encoding, queue depth and entry layout.
// Imported by the fetch sequencer and its word queue.
package fetch_redirect_pkg;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
  localparam logic [1:0]  QUEUE_DEPTH      = 2'd2;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } fetchState_e;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pcPlusTwo;
  } fetchEntry_t;

endpackage

// File: rtl/cla_16b.sv
// 16-bit carry-lookahead adder, 4-bit groups; combinational, sum wraps mod 2^16.
// No flow control.
module cla_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  logic [15:0] g, p;
  logic [2:0]  gg, pg;
  logic [3:0]  cg;
  logic        carry;

  always_comb begin
    g     = a & b;
    p     = a ^ b;
    cg    = '0;
    gg    = '0;
    pg    = '0;
    sum   = '0;
    carry = 1'b0;
    // Group carries look ahead; only the top group's carry-out is dropped.
    for (int k = 0; k < 3; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (&p[4*k+3 -: 3] & g[4*k]);
      pg[k] = &p[4*k+3 -: 4];
      cg[k+1] = gg[k] | (pg[k] & cg[k]);
    end
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) carry = cg[i/4];
      sum[i] = p[i] ^ carry;
      carry  = g[i] | (p[i] & carry);
    end
  end

endmodule

// File: rtl/dff.sv
// Standard register cell, synchronous active-high reset; latency 1 cycle.
// No flow control: d is captured every rising edge.
module dff #(
  parameter int            W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

endmodule

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched words; push-to-head latency 1 cycle, flush beats push.
// Push is dropped when full without a same-cycle pop; the producer must honour count.
module fetch_queue
  import fetch_redirect_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  fetchEntry_t pushDat,
  output fetchEntry_t headDat,
  output logic [1:0]  count
);

  fetchEntry_t e0Q, e0D, e1Q, e1D;
  logic [1:0]  cntQ, cntD, afterPop;
  logic        doPop, doPush;

  dff #(.W(32)) e0Reg  (.clk(clk), .rst(rst), .d(e0D),  .q(e0Q));
  dff #(.W(32)) e1Reg  (.clk(clk), .rst(rst), .d(e1D),  .q(e1Q));
  dff #(.W(2))  cntReg (.clk(clk), .rst(rst), .d(cntD), .q(cntQ));

  always_comb begin
    e0D      = e0Q;
    e1D      = e1Q;
    doPop    = pop && (cntQ != 2'd0);
    doPush   = push && ((cntQ < QUEUE_DEPTH) || doPop);
    afterPop = cntQ - {1'b0, doPop};
    if (doPop) e0D = e1Q;
    if (doPush) begin
      if (afterPop == 2'd0) e0D = pushDat;
      else                  e1D = pushDat;
    end
    cntD = afterPop + {1'b0, doPush};
    if (flush) cntD = 2'd0;
  end

  assign headDat = e0Q;
  assign count   = cntQ;

endmodule

// File: rtl/fetch_redirect.sv
// Fetch PC sequencer: one outstanding imem read, 2-deep word queue, decode redirect/halt.
// imem_done -> instr_valid next cycle; reads issue only while the queue has a free slot.
module fetch_redirect
  import fetch_redirect_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  input  logic        halt,
  input  logic        stall_id,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic        imem_stall,
  input  logic        imem_done,
  input  logic [15:0] imem_data,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] pc_plus_two,
  output logic        err
);

  logic [1:0]  stateQ;
  fetchState_e state, stateD;
  logic [15:0] pcQ, pcD, tagQ, tagD, pcInc;
  logic        squashQ, squashD, errQ, errD;
  logic        canIssue, accept;
  logic        qPush, qPop, qFlush;
  logic [1:0]  qCount;
  fetchEntry_t qDin, qHead;

  dff #(.W(2), .RST_VAL(FETCH)) stateReg  (.clk(clk), .rst(rst), .d(stateD),  .q(stateQ));
  dff #(.W(16), .RST_VAL(RESET_PC)) pcReg (.clk(clk), .rst(rst), .d(pcD),     .q(pcQ));
  dff #(.W(16)) tagReg                    (.clk(clk), .rst(rst), .d(tagD),    .q(tagQ));
  dff #(.W(1))  squashReg                 (.clk(clk), .rst(rst), .d(squashD), .q(squashQ));
  dff #(.W(1))  errReg                    (.clk(clk), .rst(rst), .d(errD),    .q(errQ));

  cla_16b pcAdder (.a(pcQ), .b(16'd2), .sum(pcInc));

  fetch_queue wordQueue (
    .clk(clk), .rst(rst), .push(qPush), .pop(qPop), .flush(qFlush),
    .pushDat(qDin), .headDat(qHead), .count(qCount)
  );

  assign state    = fetchState_e'(stateQ);
  assign canIssue = (state == FETCH) && (qCount < QUEUE_DEPTH);
  assign qPop     = (qCount != 2'd0) && !stall_id;
  assign qDin     = '{instr: imem_data, pcPlusTwo: tagQ};

  always_comb begin
    stateD  = state;
    pcD     = pcQ;
    tagD    = tagQ;
    squashD = squashQ;
    errD    = errQ;
    qPush   = 1'b0;
    qFlush  = 1'b0;
    accept  = canIssue && !imem_stall;
    case (state)
      FETCH: if (accept) begin
        stateD = WAIT;
        pcD    = pcInc;
        tagD   = pcInc;
      end
      WAIT: if (imem_done) begin
        qPush   = !squashQ;
        stateD  = FETCH;
        squashD = 1'b0;
      end
      default: ;
    endcase
    // Halt freezes the PC and drops any returning word; a redirect the same cycle is ignored.
    if (halt) begin
      stateD = HALTED;
      pcD    = pcQ;
      qPush  = 1'b0;
    end else if (redirect_valid && (state != HALTED)) begin
      qFlush = 1'b1;
      qPush  = 1'b0;
      pcD    = redirect_target;
      if (accept || ((state == WAIT) && !imem_done)) squashD = 1'b1;
      if (redirect_target[0]) errD = 1'b1;
    end
  end

  always_comb begin
    imem_rd     = canIssue;
    imem_addr   = pcQ;
    instr_valid = (qCount != 2'd0);
    instr       = qHead.instr;
    pc_plus_two = qHead.pcPlusTwo;
    err         = errQ;
  end

endmodule

// File: tb/tb_fetch_redirect.sv
// Randomized scoreboard bench for fetch_redirect against a queue-level fetch model
// and a variable-latency memory model that answers the DUT's actual requests.
module tb_fetch_redirect;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_target = 16'h0000;
  logic        halt = 1'b0;
  logic        stall_id = 1'b0;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic        imem_stall = 1'b0;
  logic        imem_done = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] pc_plus_two;
  logic        err;

  fetch_redirect dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt(halt), .stall_id(stall_id), .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_stall(imem_stall), .imem_done(imem_done), .imem_data(imem_data),
    .instr_valid(instr_valid), .instr(instr), .pc_plus_two(pc_plus_two), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
  } ent_t;

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic        err;
    logic        vld;
    logic        dlv;
  } cyc_t;

  cyc_t cycQ[$];
  ent_t expQ[$];

  int nVec = 0;
  int nBad = 0;

  // Reference model of the fetch stage, in terms of the architectural behaviour
  ent_t        mFifo[$];
  logic [15:0] mPc;
  logic [15:0] mTag;
  bit          mWaiting, mHalted, mSquash, mErr;

  // Memory model: one outstanding read, fixed latency per request
  bit          respPending = 0;
  int          respDelay = 0;
  logic [15:0] respData = 16'h0000;

  int pStall, pRedir, pOdd, pMemStall, latLo, latHi;
  int stallLeft = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic setKnobs(input int ps, input int pr, input int po, input int pm,
                          input int lo, input int hi);
    pStall = ps; pRedir = pr; pOdd = po; pMemStall = pm; latLo = lo; latHi = hi;
  endtask

  task automatic memStep();
    imem_done = 1'b0;
    imem_data = 16'($urandom);
    if (respPending) begin
      respDelay--;
      if (respDelay == 0) begin
        imem_done   = 1'b1;
        imem_data   = respData;
        respPending = 0;
      end
    end
  endtask

  task automatic resetDut();
    repeat (2) begin
      @(posedge clk); #1;
      rst = 1'b1;
      redirect_valid = 1'b0;
      halt = 1'b0;
      stall_id = 1'b0;
      memStep();
      imem_stall = 1'b1;
    end
    mFifo.delete();
    mPc = 16'h0000;
    mTag = 16'h0000;
    mWaiting = 0; mHalted = 0; mSquash = 0; mErr = 0;
    stallLeft = 0;
  endtask

  task automatic doCycle(input bit doHalt);
    cyc_t        c;
    bit          expRd, got;
    ent_t        gotEnt;
    logic [15:0] t;
    @(posedge clk); #1;
    rst = 1'b0;
    memStep();
    if (!imem_done && !respPending && !mWaiting && $urandom_range(0, 19) == 0) imem_done = 1'b1;
    imem_stall = respPending || ($urandom_range(0, 99) < pMemStall);
    if (stallLeft > 0) begin
      stall_id = 1'b1; stallLeft--;
    end else if ($urandom_range(0, 99) < pStall) begin
      stall_id = 1'b1; stallLeft = $urandom_range(0, 7);
    end else begin
      stall_id = 1'b0;
    end
    halt = doHalt || mHalted;
    redirect_valid = !mHalted && ($urandom_range(0, 99) < pRedir);
    t = 16'($urandom);
    if ($urandom_range(0, 3) == 0) t[15:3] = '1;
    if ($urandom_range(0, 99) >= pOdd) t[0] = 1'b0;
    redirect_target = t;

    if (imem_rd && !imem_stall) begin
      respPending = 1;
      respDelay   = $urandom_range(latLo, latHi);
      respData    = 16'($urandom);
    end

    expRd  = !mWaiting && !mHalted && (mFifo.size() < 2);
    c.rd   = expRd;
    c.addr = mPc;
    c.err  = mErr;
    c.vld  = (mFifo.size() != 0);
    c.dlv  = (mFifo.size() != 0) && !stall_id;
    cycQ.push_back(c);

    if (c.dlv) expQ.push_back(mFifo.pop_front());
    if (mHalted) begin
    end else if (halt) begin
      mHalted = 1;
    end else begin
      got    = mWaiting && imem_done && !mSquash;
      gotEnt = '{instr: imem_data, pc2: mTag};
      if (mWaiting && imem_done) begin
        mWaiting = 0; mSquash = 0;
      end
      if (expRd && !imem_stall) begin
        mWaiting = 1;
        mPc = mPc + 16'd2;
        mTag = mPc;
      end
      if (redirect_valid) begin
        mFifo.delete();
        mPc = redirect_target;
        if (mWaiting) mSquash = 1;
        if (redirect_target[0]) mErr = 1;
      end else if (got) begin
        mFifo.push_back(gotEnt);
      end
    end
  endtask

  task automatic runPhase(input int n, input int haltAt);
    for (int i = 0; i < n; i++) doCycle(i == haltAt);
  endtask

  // Monitor: checks every modelled cycle and pops the scoreboard on each handshake
  initial begin
    cyc_t c;
    ent_t e;
    forever begin
      @(negedge clk);
      if (cycQ.size() != 0) begin
        c = cycQ.pop_front();
        chk("imem_rd", {31'b0, imem_rd}, {31'b0, c.rd});
        chk("imem_addr", {16'b0, imem_addr}, {16'b0, c.addr});
        chk("err", {31'b0, err}, {31'b0, c.err});
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, c.vld});
        chk("handshake", {31'b0, instr_valid & ~stall_id}, {31'b0, c.dlv});
        if (c.dlv) begin
          e = expQ.pop_front();
          chk("instr", {16'b0, instr}, {16'b0, e.instr});
          chk("pc_plus_two", {16'b0, pc_plus_two}, {16'b0, e.pc2});
        end
      end
    end
  end

  initial begin
    setKnobs(0, 0, 0, 0, 1, 1);
    resetDut();
    runPhase(40, -1);
    setKnobs(35, 0, 0, 0, 1, 2);
    runPhase(200, -1);
    resetDut();
    setKnobs(10, 15, 0, 20, 1, 4);
    runPhase(400, -1);
    setKnobs(10, 15, 30, 10, 1, 3);
    runPhase(150, -1);
    for (int h = 0; h < 4; h++) begin
      resetDut();
      setKnobs(20, 10, 0, 10, 2, 4);
      runPhase(60, 20 + h * 7);
    end
    for (int r = 0; r < 6; r++) begin
      resetDut();
      setKnobs(10, 10, 10, 10, 1, 4);
      runPhase($urandom_range(3, 20), -1);
    end
    resetDut();
    setKnobs(25, 12, 10, 20, 1, 4);
    runPhase(1500, -1);
    @(negedge clk); #1;
    chk("cycle_queue_drained", cycQ.size(), 0);
    chk("scoreboard_drained", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
